cla_adder_4bit: RTL and testbench

- Registered carry-lookahead adder. Computes s = a + b + cin with full lookahead carry logic (no ripple) and registers the result on the clock edge.
- Serves as the binary adder primitive inside BCD and other arithmetic datapaths, e.g. a first-stage binary add followed by a +6 decimal-correction add.
- WIDTH is a multiple of 4: 4-bit lookahead groups joined by a second-level group-lookahead carry unit.

---
 rtl/cla_adder_4bit_if.sv | 25 ++
 rtl/cla_adder_4bit.sv | 107 ++++++++++
 tb/tb_cla_adder_4bit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cla_adder_4bit_if.sv
// Operand/result bundle for the registered carry-lookahead adder.
// The master side drives operands; the slave side (the adder) returns the registered result.
interface cla_adder_4bit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             gg;
  logic             gp;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  s, cout, gg, gp, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output s, cout, gg, gp, out_valid
  );
endinterface

// File: rtl/cla_adder_4bit.sv
// Registered carry-lookahead adder: 4-bit lookahead groups joined by a flat
// second-level group-lookahead unit, one register stage on the outputs.
module cla_adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  cla_adder_4bit_if.slave bus
);
  localparam int NGRP = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("cla_adder_4bit: WIDTH must be a positive multiple of 4");
  end

  // Flat sum-of-products lookahead across groups: carry into group k is built
  // directly from group G/P and ci, never from the carry-out of group k-1.
  function automatic logic group_carry(input logic [NGRP-1:0] gv,
                                       input logic [NGRP-1:0] pv,
                                       input logic            ci,
                                       input int              k);
    logic acc;
    logic term;
    acc = ci;
    for (int i = 0; i < k; i++) acc = acc & pv[i];
    for (int j = 0; j < k; j++) begin
      term = gv[j];
      for (int i = j + 1; i < k; i++) term = term & pv[i];
      acc = acc | term;
    end
    return acc;
  endfunction

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    grp_c;

  assign g = bus.a & bus.b;
  assign p = bus.a ^ bus.b;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    logic [3:0] gl;
    logic [3:0] pl;
    logic       c0;

    assign gl = g[4*k +: 4];
    assign pl = p[4*k +: 4];
    assign c0 = grp_c[k];

    assign c[4*k]   = c0;
    assign c[4*k+1] = gl[0] | (pl[0] & c0);
    assign c[4*k+2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & c0);
    assign c[4*k+3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                    | (pl[2] & pl[1] & pl[0] & c0);

    assign grp_p[k] = &pl;
    assign grp_g[k] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                    | (pl[3] & pl[2] & pl[1] & gl[0]);
  end

  assign grp_c[0] = bus.cin;
  for (genvar k = 1; k <= NGRP; k++) begin : g_gcarry
    assign grp_c[k] = group_carry(grp_g, grp_p, bus.cin, k);
  end

  logic [WIDTH-1:0] sum_next;
  logic             gg_next;
  logic             gp_next;

  assign sum_next = p ^ c;
  // Whole-word generate is the word carry-out with the carry-in forced low.
  assign gg_next  = group_carry(grp_g, grp_p, 1'b0, NGRP);
  assign gp_next  = &grp_p;

  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             gg_q;
  logic             gp_q;
  logic             out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      gg_q        <= 1'b0;
      gp_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      s_q         <= sum_next;
      cout_q      <= grp_c[NGRP];
      gg_q        <= gg_next;
      gp_q        <= gp_next;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.gg        = gg_q;
  assign bus.gp        = gp_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_cla_adder_4bit.sv
// Scoreboard bench for cla_adder_4bit: 4-bit and 16-bit instances, expected
// results queued at issue time and checked by per-instance monitors.
module tb_cla_adder_4bit;
  logic clk;
  logic rst;

  cla_adder_4bit_if #(.WIDTH(4))  if4 ();
  cla_adder_4bit_if #(.WIDTH(16)) if16 ();

  cla_adder_4bit #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
  cla_adder_4bit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        gg;
    logic        gp;
  } exp_t;

  exp_t q4[$];
  exp_t q16[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (if4.out_valid === 1'b1) begin
        if (q4.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL w4 unexpected out_valid: got 1, required 0");
        end else begin
          exp_t e;
          e = q4.pop_front();
          check("w4 s",    {28'd0, if4.s}, {16'd0, e.s});
          check("w4 cout", {31'd0, if4.cout}, {31'd0, e.cout});
          check("w4 gg",   {31'd0, if4.gg},   {31'd0, e.gg});
          check("w4 gp",   {31'd0, if4.gp},   {31'd0, e.gp});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (if16.out_valid === 1'b1) begin
        if (q16.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL w16 unexpected out_valid: got 1, required 0");
        end else begin
          exp_t e;
          e = q16.pop_front();
          check("w16 s",    {16'd0, if16.s}, {16'd0, e.s});
          check("w16 cout", {31'd0, if16.cout}, {31'd0, e.cout});
          check("w16 gg",   {31'd0, if16.gg},   {31'd0, e.gg});
          check("w16 gp",   {31'd0, if16.gp},   {31'd0, e.gp});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic [3:0] es, input logic ec, input logic egg, input logic egp);
    exp_t e;
    e.s = {12'd0, es}; e.cout = ec; e.gg = egg; e.gp = egp;
    q4.push_back(e);
    if4.a = a; if4.b = b; if4.cin = cin; if4.in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] es, input logic ec, input logic egg, input logic egp);
    exp_t e;
    e.s = es; e.cout = ec; e.gg = egg; e.gp = egp;
    q16.push_back(e);
    if16.a = a; if16.b = b; if16.cin = cin; if16.in_valid = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [4:0]  r5;
    logic [16:0] r17;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    rst = 1'b1;
    if4.in_valid = 1'b0;  if4.a = '0;  if4.b = '0;  if4.cin = 1'b0;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset w4 s",         {28'd0, if4.s}, 32'd0);
    check("reset w4 cout",      {31'd0, if4.cout}, 32'd0);
    check("reset w4 gg",        {31'd0, if4.gg}, 32'd0);
    check("reset w4 gp",        {31'd0, if4.gp}, 32'd0);
    check("reset w4 out_valid", {31'd0, if4.out_valid}, 32'd0);
    check("reset w16 s",        {16'd0, if16.s}, 32'd0);
    check("reset w16 out_valid",{31'd0, if16.out_valid}, 32'd0);
    rst = 1'b0;

    // Directed 4-bit vectors, expected values worked by hand.
    send4(4'd9, 4'd8, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0);
    send4(4'hF, 4'h0, 1'b1, 4'h0,    1'b1, 1'b0, 1'b1);
    send4(4'h0, 4'h0, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0);
    send4(4'd7, 4'd2, 1'b0, 4'd9,    1'b0, 1'b0, 1'b0);
    if4.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold w4 s",         {28'd0, if4.s}, 32'd9);
      check("hold w4 out_valid", {31'd0, if4.out_valid}, 32'd0);
    end

    rst = 1'b1;
    if4.a = 4'd5; if4.b = 4'd5; if4.cin = 1'b0; if4.in_valid = 1'b1;
    @(negedge clk);
    check("midrst w4 s",         {28'd0, if4.s}, 32'd0);
    check("midrst w4 cout",      {31'd0, if4.cout}, 32'd0);
    check("midrst w4 out_valid", {31'd0, if4.out_valid}, 32'd0);
    rst = 1'b0;
    send4(4'd3, 4'd4, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);

    // Exhaustive 4-bit sweep, back-to-back.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          r5 = 5'(ia) + 5'(ib) + 5'(ic);
          send4(4'(ia), 4'(ib), 1'(ic), r5[3:0], r5[4],
                (5'(ia) + 5'(ib)) > 5'd15, (4'(ia) ^ 4'(ib)) == 4'hF);
        end
      end
    end
    if4.in_valid = 1'b0;
    @(negedge clk);

    send16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    send16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    send16(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    send16(16'h1234, 16'h0F0F, 1'b1, 16'h2144, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom);
      r17 = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      send16(ra, rb, rc, r17[15:0], r17[16],
             ({1'b0, ra} + {1'b0, rb}) > 17'h0FFFF, (ra ^ rb) == 16'hFFFF);
    end
    if16.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    check("w4 queue drained",  q4.size(), 32'd0);
    check("w16 queue drained", q16.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
